// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
//   arb_state_e : transaction FSM states (idle, memory held, ack)
//   REQ_*       : requester indices; lower index = higher fixed priority
//   *_W         : address / data / byte-enable widths of one requester slice
//   idx_w()     : index width helper that never returns zero
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } arb_state_e;

  localparam int unsigned REQ_DCACHE = 0;
  localparam int unsigned REQ_ICACHE = 1;
  localparam int unsigned REQ_SB     = 2;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the data-memory port arbiter.
// Build option MEM_ARB_RR_EN: round-robin search starting after last_i.
// Default build: lowest index wins unless promote_i forces requester NREQ-1.
// Ports:
//   req_i     : per-requester request vector
//   last_i    : index of the previous grant (round-robin build only)
//   promote_i : aged requester NREQ-1 must win (fixed-priority build only)
//   gnt_o     : one-hot winner, all zero when no request
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0]            req_i,
`ifdef MEM_ARB_RR_EN
  input  logic [idx_w(NREQ)-1:0]     last_i,
`else
  input  logic                       promote_i,
`endif
  output logic [NREQ-1:0]            gnt_o
);

`ifdef MEM_ARB_RR_EN
  // Walk offsets 1..NREQ after the last winner; the first requester hit wins.
  int unsigned cand;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && (cand == i) && req_i[i]) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    gnt_o = '0;
    if (promote_i) begin
      gnt_o[NREQ-1] = 1'b1;
    end else begin
      // Descending scan so the lowest requesting index is written last.
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
        if (req_i[i]) begin
          gnt_o    = '0;
          gnt_o[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data_memory port among NREQ requesters (0 dcache, 1 icache,
// 2 store buffer), one transaction at a time, holding memory MEM_LATENCY cycles.
// Build option MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with
// requester NREQ-1 promoted after AGE_MAX lost arbitrations.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   req_i / req_we_i        : per-requester request and write flag
//   req_addr_i/wdata_i/be_i : flattened per-requester address, data, byte enables
//   ack_o                   : one-hot one-cycle completion pulse
//   rdata_o                 : read data, valid in the ack cycle, held otherwise
//   grant_o / busy_o        : owner of the in-flight transaction / in flight
//   mem_*                   : data_memory interface
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned AGE_MAX     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [ADDR_W*NREQ-1:0] req_addr_i,
  input  logic [DATA_W*NREQ-1:0] req_wdata_i,
  input  logic [BE_W*NREQ-1:0]   req_be_i,
  output logic [NREQ-1:0]        ack_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic [NREQ-1:0]        grant_o,
  output logic                   busy_o,
  output logic                   mem_read_en_o,
  output logic                   mem_write_en_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  output logic [BE_W-1:0]        mem_byte_en_o,
  input  logic [DATA_W-1:0]      mem_rdata_i
);

  localparam int unsigned CntW = idx_w(MEM_LATENCY);

  arb_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0]     pick_gnt;
  logic                arb_now;

  // An arbitration happens only in an idle cycle with at least one request.
  assign arb_now = (state_q == StIdle) && (|req_i);

`ifdef MEM_ARB_RR_EN
  localparam int unsigned PtrW = idx_w(NREQ);
  logic [PtrW-1:0] last_q, last_d, win_idx;

  always_comb begin
    win_idx = last_q;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_gnt[i]) win_idx = PtrW'(i);
    end
    last_d = arb_now ? win_idx : last_q;
  end

  // Reset to NREQ-1 so the first search starts at requester 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= PtrW'(NREQ - 1);
    else         last_q <= last_d;
  end
`else
  localparam int unsigned AgeW = idx_w(AGE_MAX + 1);
  logic [AgeW-1:0] age_q, age_d;
  logic            promote;

  assign promote = (age_q == AgeW'(AGE_MAX)) && req_i[NREQ-1];

  // Counts lost idle arbitrations of requester NREQ-1, saturating at AGE_MAX.
  always_comb begin
    age_d = age_q;
    if (!req_i[NREQ-1]) begin
      age_d = '0;
    end else if (arb_now) begin
      if (pick_gnt[NREQ-1])               age_d = '0;
      else if (age_q != AgeW'(AGE_MAX))   age_d = age_q + AgeW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) age_q <= '0;
    else         age_q <= age_d;
  end
`endif

  mem_arb_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i     (req_i),
`ifdef MEM_ARB_RR_EN
    .last_i    (last_q),
`else
    .promote_i (promote),
`endif
    .gnt_o     (pick_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    case (state_q)
      StIdle: begin
        if (arb_now) begin
          grant_d = pick_gnt;
          for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_gnt[i]) begin
              we_d    = req_we_i[i];
              addr_d  = req_addr_i[ADDR_W*i +: ADDR_W];
              wdata_d = req_wdata_i[DATA_W*i +: DATA_W];
              be_d    = req_be_i[BE_W*i +: BE_W];
            end
          end
          cnt_d   = CntW'(MEM_LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          if (!we_q) rdata_d = mem_rdata_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        grant_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decode from state only, so an async reset drops every enable at once.
  assign busy_o         = (state_q != StIdle);
  assign grant_o        = grant_q;
  assign ack_o          = (state_q == StDone) ? grant_q : '0;
  assign rdata_o        = rdata_q;
  assign mem_read_en_o  = (state_q == StBusy) && !we_q;
  assign mem_write_en_o = (state_q == StBusy) && we_q && (cnt_q == '0);
  assign mem_addr_o     = (state_q == StBusy) ? addr_q  : '0;
  assign mem_wdata_o    = (state_q == StBusy) ? wdata_q : '0;
  assign mem_byte_en_o  = (state_q == StBusy) ? be_q    : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned N       = 3;
  localparam int unsigned L       = 2;
  localparam int unsigned AGE_MAX = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, req_we, ack, grant;
  logic [32*N-1:0] req_addr, req_wdata;
  logic [4*N-1:0]  req_be;
  logic [31:0]     rdata, mem_addr, mem_wdata, mem_rdata;
  logic            busy, mem_read_en, mem_write_en;
  logic [3:0]      mem_byte_en;

  mem_port_arbiter #(
    .NREQ        (N),
    .MEM_LATENCY (L),
    .AGE_MAX     (AGE_MAX)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_i          (req),
    .req_we_i       (req_we),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_be_i       (req_be),
    .ack_o          (ack),
    .rdata_o        (rdata),
    .grant_o        (grant),
    .busy_o         (busy),
    .mem_read_en_o  (mem_read_en),
    .mem_write_en_o (mem_write_en),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_byte_en_o  (mem_byte_en),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level reference: phase 0 idle, 1..L memory held, L+1 ack.
  int          m_phase, m_owner, m_age, m_last;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  // Stimulus agents: mode 0 directed, 1 hold all requests, 2 random.
  int mode;
  bit active [N];
  int cyc, n_rd, n_wr, wr_cyc, last_ack_cyc;
  int n_ack [N];
  logic [31:0] last_ack_rdata;
  bit prev_busy;
  int glog [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (bit_of(v, i)) return i;
    return -1;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] r);
`ifdef MEM_ARB_RR_EN
    for (int k = 1; k <= int'(N); k++) if (bit_of(r, (m_last + k) % int'(N))) return (m_last + k) % int'(N);
`else
    if (bit_of(r, int'(N) - 1) && m_age >= int'(AGE_MAX)) return int'(N) - 1;
    for (int i = 0; i < int'(N); i++) if (bit_of(r, i)) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_age = 0; m_last = int'(N) - 1; m_rdata = '0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0;
  endtask

  task automatic model_advance();
    int w;
    if (m_phase == 0) begin
      if (req != '0) begin
        w = ref_pick(req);
`ifdef MEM_ARB_RR_EN
        m_last = w;
`else
        if (w == int'(N) - 1 || !bit_of(req, int'(N) - 1)) m_age = 0;
        else if (m_age < int'(AGE_MAX)) m_age++;
`endif
        m_owner = w;
        m_we    = bit_of(req_we, w);
        m_addr  = 32'(req_addr >> (32 * w));
        m_wdata = 32'(req_wdata >> (32 * w));
        m_be    = 4'(req_be >> (4 * w));
        m_phase = 1;
      end
    end else if (m_phase <= int'(L)) begin
      if (m_phase == int'(L) && !m_we) m_rdata = mem_rdata;
      m_phase++;
    end else begin
      m_phase = 0;
    end
`ifndef MEM_ARB_RR_EN
    if (!bit_of(req, int'(N) - 1)) m_age = 0;
`endif
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_grant, e_ack;
    logic e_busy, e_rd, e_wr;
    e_grant = '0; e_ack = '0; e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
    if (m_phase >= 1) begin
      e_busy  = 1'b1;
      e_grant = N'(1) << m_owner;
    end
    if (m_phase == int'(L) + 1) e_ack = e_grant;
    if (m_phase >= 1 && m_phase <= int'(L)) begin
      e_rd = !m_we;
      e_wr = m_we && (m_phase == int'(L));
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_byte_en", 32'(mem_byte_en), 32'(m_be));
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("mem_read_en", 32'(mem_read_en), 32'(e_rd));
    chk("mem_write_en", 32'(mem_write_en), 32'(e_wr));
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic rand_data(input int i);
    req_we[i] = 1'($urandom_range(0, 1));
    req_addr[32*i +: 32] = $urandom();
    req_wdata[32*i +: 32] = $urandom();
    req_be[4*i +: 4] = 4'($urandom());
  endtask

  task automatic start_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] be);
    active[i] = 1'b1;
    req_we[i] = we;
    req_addr[32*i +: 32] = a;
    req_wdata[32*i +: 32] = d;
    req_be[4*i +: 4] = be;
  endtask

  task automatic drive_agents();
    bit acked;
    for (int i = 0; i < int'(N); i++) begin
      acked = (mode != 1) && bit_of(ack, i);
      if (acked) active[i] = 1'b0;
      if (mode == 2 && !acked) begin
        if (!active[i]) begin
          if ($urandom_range(0, 3) == 0) begin active[i] = 1'b1; rand_data(i); end
        end else if (m_phase > 0 && m_owner == i && $urandom_range(0, 11) == 0) begin
          active[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          rand_data(i);
        end
      end
      req[i] = active[i];
    end
    if (mode != 0) mem_rdata = $urandom();
  endtask

  // One clock: check at the falling edge, drive inputs, advance the model.
  task automatic cycle();
    check_outputs();
    if (mem_read_en) n_rd++;
    if (mem_write_en) begin n_wr++; wr_cyc = cyc; end
    for (int i = 0; i < int'(N); i++) begin
      if (bit_of(ack, i)) begin
        n_ack[i]++; last_ack_cyc = cyc; last_ack_rdata = rdata;
      end
    end
    if (busy && !prev_busy) glog.push_back(onehot_idx(grant));
    prev_busy = busy;
    drive_agents();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drop_all();
    for (int i = 0; i < int'(N); i++) active[i] = 1'b0;
  endtask

  initial begin
    int t, rd0, wr0, ack0, rises0;
    int exp_seq [10];

    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    mem_rdata = '0; mode = 0; cyc = 0; n_rd = 0; n_wr = 0; wr_cyc = -1; last_ack_cyc = -1;
    last_ack_rdata = '0; prev_busy = 1'b0;
    for (int i = 0; i < int'(N); i++) begin n_ack[i] = 0; active[i] = 1'b0; end
    model_reset();
    #2;
    check_outputs();
    chk("reset_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Single read by the icache.
    mem_rdata = 32'hDEAD_BEEF;
    start_req(1, 1'b0, 32'h40, 32'h0, 4'hF);
    t = cyc; rd0 = n_rd;
    repeat (6) cycle();
    chk("t1_ack_latency", 32'(last_ack_cyc - t), 32'(L + 1));
    chk("t1_read_cycles", 32'(n_rd - rd0), 32'(L));
    chk("t1_rdata", last_ack_rdata, 32'hDEAD_BEEF);

    // Single write by the store buffer.
    mem_rdata = 32'h5555_AAAA;
    start_req(2, 1'b1, 32'h80, 32'h1122_3344, 4'hF);
    t = cyc; wr0 = n_wr;
    repeat (6) cycle();
    chk("t2_write_pulses", 32'(n_wr - wr0), 32'd1);
    chk("t2_write_cycle", 32'(wr_cyc - t), 32'(L));
    chk("t2_ack_latency", 32'(last_ack_cyc - t), 32'(L + 1));
    chk("t2_rdata_kept", last_ack_rdata, 32'hDEAD_BEEF);

    // All requesters held high.
`ifdef MEM_ARB_RR_EN
    exp_seq = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0};
`endif
    mode = 1;
    glog.delete();
    for (int i = 0; i < int'(N); i++) begin active[i] = 1'b1; rand_data(i); end
    repeat (44) cycle();
    chk("t3_grant_count", 32'(glog.size() >= 10), 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k < glog.size()) chk($sformatf("t3_grant_seq%0d", k), 32'(glog[k]), 32'(exp_seq[k]));
    end
    mode = 0;
    drop_all();
    repeat (6) cycle();

    // Requester 0 drops its request mid-transaction.
    start_req(0, 1'b0, 32'h100, 32'h0, 4'h3);
    ack0 = n_ack[0]; glog.delete();
    cycle();
    cycle();
    active[0] = 1'b0;
    repeat (8) cycle();
    chk("t6_ack_once", 32'(n_ack[0] - ack0), 32'd1);
    chk("t6_no_rearb", 32'(glog.size()), 32'd1);

    // Randomized traffic.
    mode = 2;
    repeat (1500) cycle();
    mode = 0;
    drop_all();
    repeat (8) cycle();

    // Asynchronous reset during the first held cycle of a write.
    start_req(0, 1'b1, 32'hC0, 32'hCAFE_F00D, 4'hF);
    cycle();
    wr0 = n_wr;
    rises0 = n_ack[0];
    rst_n = 1'b0;
    drop_all();
    req = '0;
    model_reset();
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_mem_write_en", 32'(mem_write_en), 32'd0);
    chk("t5_mem_read_en", 32'(mem_read_en), 32'd0);
    chk("t5_mem_addr", mem_addr, 32'h0);
    chk("t5_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("t5_write_en_held", 32'(mem_write_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_busy = 1'b0;
    repeat (6) cycle();
    chk("t5_no_write", 32'(n_wr - wr0), 32'd0);
    chk("t5_no_ack", 32'(n_ack[0] - rises0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
